mem_arbiter: RTL and testbench

Single-port memory arbiter for the five-stage pipeline. Shares one unified instruction/data memory between the IF-stage fetch port and the MEM-stage load/store port. Sequences each access through a fixed-latency memory and returns read data with a one-cycle acknowledge. Generates per-port stall signals that the control unit folds into PC/IR write enable and pipeline freezing.

---
 rtl/mem_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: IF fetch and MEM load/store share one fixed-latency memory.
// Data has priority; a saturating grant counter lets a waiting fetch in after MAX_DGRANT data grants.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int MAX_DGRANT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_ack,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [DATA_W/8-1:0] dm_be,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    output logic                dm_ack,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                stall_if,
    output logic                stall_dm,
    output logic [1:0]          dbg_state
);

    // Handshake: a requester holds req and its operands stable until a one-cycle ack;
    // ack means the access is complete and rdata is valid in that same cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [3:0] LAT  = 4'(MEM_LAT);
    localparam logic [3:0] MAXD = 4'(MAX_DGRANT);

    state_t     state, state_nxt;
    logic [3:0] lat_cnt;
    logic [3:0] dcnt;
    logic       gnt_dm;
    logic       grant_dm, grant_if;

    always_comb begin
        state_nxt = state;
        grant_dm  = 1'b0;
        grant_if  = 1'b0;
        case (state)
            IDLE: begin
                if (dm_req && !(if_req && dcnt == MAXD)) begin
                    grant_dm  = 1'b1;
                    state_nxt = CMD;
                end else if (if_req) begin
                    grant_if  = 1'b1;
                    state_nxt = CMD;
                end
            end
            CMD:     state_nxt = WAIT;
            WAIT:    if (lat_cnt == 4'd1) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            dcnt      <= '0;
            gnt_dm    <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ack    <= 1'b0;
            dm_ack    <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            state  <= state_nxt;
            mem_en <= 1'b0;
            if_ack <= 1'b0;
            dm_ack <= 1'b0;

            if (grant_dm) begin
                mem_en    <= 1'b1;
                mem_we    <= dm_we;
                mem_be    <= dm_be;
                mem_addr  <= dm_addr;
                mem_wdata <= dm_wdata;
                gnt_dm    <= 1'b1;
                // Only data grants that overtake a waiting fetch count toward the limit.
                if (if_req) dcnt <= (dcnt == MAXD) ? MAXD : dcnt + 4'd1;
                else        dcnt <= '0;
            end

            if (grant_if) begin
                mem_en    <= 1'b1;
                mem_we    <= 1'b0;
                mem_be    <= '1;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
                gnt_dm    <= 1'b0;
                dcnt      <= '0;
            end

            if (state == CMD) lat_cnt <= LAT;

            if (state == WAIT) begin
                if (lat_cnt == 4'd1) begin
                    if (gnt_dm) begin
                        if (!mem_we) dm_rdata <= mem_rdata;
                        dm_ack <= 1'b1;
                    end else begin
                        if_rdata <= mem_rdata;
                        if_ack   <= 1'b1;
                    end
                end else begin
                    lat_cnt <= lat_cnt - 4'd1;
                end
            end
        end
    end

    assign stall_if  = if_req & ~if_ack;
    assign stall_dm  = dm_req & ~dm_ack;
    assign dbg_state = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of single accesses plus hand-written
// sequences for contention, the data-grant limit and asynchronous reset in WAIT.
module tb_mem_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int BE_W       = DATA_W / 8;
    localparam int MEM_LAT    = 2;
    localparam int MAX_DGRANT = 4;
    localparam int ACK_CYC    = MEM_LAT + 2;
    localparam int PERIOD_ACC = MEM_LAT + 3;

    logic              clk;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              dm_req;
    logic              dm_we;
    logic [BE_W-1:0]   dm_be;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_ack;
    logic [DATA_W-1:0] dm_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [BE_W-1:0]   mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              stall_if;
    logic              stall_dm;
    logic [1:0]        dbg_state;

    mem_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MEM_LAT   (MEM_LAT),
        .MAX_DGRANT(MAX_DGRANT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ack   (if_ack),
        .if_rdata (if_rdata),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_be    (dm_be),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_ack   (dm_ack),
        .dm_rdata (dm_rdata),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_be   (mem_be),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .stall_if (stall_if),
        .stall_dm (stall_dm),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // ---------------- memory model ----------------
    // Read data is only valid in the exact cycle MEM_LAT after the command; garbage otherwise.
    int                lat_ctr = -1;
    logic [ADDR_W-1:0] lat_addr = '0;

    function automatic logic [DATA_W-1:0] mem_val(input logic [ADDR_W-1:0] a);
        if (a == 32'h0000_0100) return 32'h2002_0005;
        return a ^ 32'hA5A5_0000;
    endfunction

    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            lat_ctr = -1;
        end else if (mem_en) begin
            lat_ctr  = MEM_LAT;
            lat_addr = mem_addr;
        end else if (lat_ctr >= 0) begin
            lat_ctr = lat_ctr - 1;
        end
        mem_rdata = (lat_ctr == 0) ? mem_val(lat_addr) : 32'hBAD0_BAD0;
    end

    // ---------------- scoreboard ----------------
    int                n_checks = 0;
    int                n_fail   = 0;
    logic [DATA_W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: expected event did not occur at %0t", name, $time);
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if_req   = 1'b0;
        if_addr  = '0;
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        dm_be    = '0;
        dm_addr  = '0;
        dm_wdata = '0;
    endtask

    typedef struct {
        logic              is_dm;
        logic              we;
        logic [BE_W-1:0]   be;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [ADDR_W-1:0] exp_addr;
        logic              exp_we;
        logic [BE_W-1:0]   exp_be;
        logic [DATA_W-1:0] exp_wdata;
        logic [DATA_W-1:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    // Starts and ends one cycle after a rising edge with the DUT in IDLE.
    task automatic apply_single(input int idx, input vec_t v);
        bit acked;
        int en_cnt;
        string tag;
        acked  = 1'b0;
        en_cnt = 0;
        tag    = $sformatf("vec%0d", idx);
        if (v.is_dm) begin
            dm_req   = 1'b1;
            dm_we    = v.we;
            dm_be    = v.be;
            dm_addr  = v.addr;
            dm_wdata = v.wdata;
            if_addr  = $urandom;
        end else begin
            if_req   = 1'b1;
            if_addr  = v.addr;
            dm_we    = 1'b1;
            dm_be    = BE_W'($urandom);
            dm_addr  = $urandom;
            dm_wdata = $urandom;
        end
        exp_q.push_back(v.exp_rdata);
        for (int cyc = 0; cyc < ACK_CYC + 6 && !acked; cyc++) begin
            @(negedge clk);
            if (cyc == 0) chk({tag, "_idle"}, 64'(dbg_state), 64'(0));
            if (mem_en) begin
                en_cnt++;
                chk({tag, "_en_cycle"}, 64'(cyc), 64'(1));
                chk({tag, "_mem_addr"}, 64'(mem_addr), 64'(v.exp_addr));
                chk({tag, "_mem_we"}, 64'(mem_we), 64'(v.exp_we));
                chk({tag, "_mem_be"}, 64'(mem_be), 64'(v.exp_be));
                chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(v.exp_wdata));
            end
            chk({tag, "_other_ack"}, 64'(v.is_dm ? if_ack : dm_ack), 64'(0));
            chk({tag, "_stall"}, 64'(v.is_dm ? stall_dm : stall_if), 64'(cyc != ACK_CYC));
            if (v.is_dm ? dm_ack : if_ack) begin
                acked = 1'b1;
                chk({tag, "_ack_cycle"}, 64'(cyc), 64'(ACK_CYC));
                chk({tag, "_rdata"}, 64'(v.is_dm ? dm_rdata : if_rdata), 64'(exp_q.pop_front()));
                chk({tag, "_en_count"}, 64'(en_cnt), 64'(1));
            end
            step();
            if (acked) clear_inputs();
        end
        if (!acked) begin
            fail_now({tag, "_ack_timeout"});
            exp_q.delete();
            clear_inputs();
        end
    endtask

    // Holds fetch (0x500) and load (0x600) requests; a fetch request drops after its ack.
    task automatic run_both(input int n, input logic [15:0] exp_order, input string tag, input bit keep);
        int got, last_ack;
        bit prev_en, saw_if;
        got      = 0;
        last_ack = -1;
        prev_en  = 1'b0;
        if_req   = 1'b1;
        if_addr  = 32'h0000_0500;
        dm_req   = 1'b1;
        dm_we    = 1'b0;
        dm_be    = '1;
        dm_addr  = 32'h0000_0600;
        for (int cyc = 0; cyc < n * PERIOD_ACC + 10 && got < n; cyc++) begin
            @(negedge clk);
            if (mem_en) chk({tag, "_en_b2b"}, 64'(prev_en), 64'(0));
            prev_en = mem_en;
            saw_if  = if_ack;
            if (if_ack || dm_ack) begin
                chk({tag, "_ack_onehot"}, 64'(if_ack && dm_ack), 64'(0));
                chk($sformatf("%s_order%0d", tag, got), 64'(if_ack), 64'(exp_order[got]));
                chk($sformatf("%s_rdata%0d", tag, got), 64'(if_ack ? if_rdata : dm_rdata),
                    64'(if_ack ? 32'hA5A5_0500 : 32'hA5A5_0600));
                if (got > 0) chk($sformatf("%s_spacing%0d", tag, got), 64'(cyc - last_ack), 64'(PERIOD_ACC));
                else         chk({tag, "_first_lat"}, 64'(cyc), 64'(ACK_CYC));
                last_ack = cyc;
                got++;
            end
            step();
            if (saw_if) if_req = 1'b0;
            if (got == n && !keep) clear_inputs();
        end
        if (got < n) begin
            fail_now({tag, "_ack_timeout"});
            clear_inputs();
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_mem_en"}, 64'(mem_en), 64'(0));
        chk({tag, "_mem_we"}, 64'(mem_we), 64'(0));
        chk({tag, "_mem_be"}, 64'(mem_be), 64'(0));
        chk({tag, "_mem_addr"}, 64'(mem_addr), 64'(0));
        chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(0));
        chk({tag, "_acks"}, 64'({if_ack, dm_ack}), 64'(0));
        chk({tag, "_if_rdata"}, 64'(if_rdata), 64'(0));
        chk({tag, "_dm_rdata"}, 64'(dm_rdata), 64'(0));
        chk({tag, "_state"}, 64'(dbg_state), 64'(0));
    endtask

    // ---------------- test ----------------
    initial begin
        vecs[0] = '{1'b0, 1'b0, 4'h0, 32'h0000_0100, 32'h0,
                    32'h0000_0100, 1'b0, 4'hF, 32'h0, 32'h2002_0005};
        vecs[1] = '{1'b1, 1'b1, 4'h3, 32'h0000_0040, 32'hDEAD_BEEF,
                    32'h0000_0040, 1'b1, 4'h3, 32'hDEAD_BEEF, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 4'hF, 32'h0000_0200, 32'h0,
                    32'h0000_0200, 1'b0, 4'hF, 32'h0, 32'hA5A5_0200};
        vecs[3] = '{1'b1, 1'b1, 4'hC, 32'h0000_0044, 32'h1234_5678,
                    32'h0000_0044, 1'b1, 4'hC, 32'h1234_5678, 32'hA5A5_0200};
        vecs[4] = '{1'b0, 1'b0, 4'h0, 32'h0000_0104, 32'h0,
                    32'h0000_0104, 1'b0, 4'hF, 32'h0, 32'hA5A5_0104};
        vecs[5] = '{1'b1, 1'b0, 4'h5, 32'h0000_03FC, 32'hCAFE_F00D,
                    32'h0000_03FC, 1'b0, 4'h5, 32'hCAFE_F00D, 32'hA5A5_03FC};

        rst = 1'b0;
        clear_inputs();

        // Reset held with random requests.
        for (int i = 0; i < 3; i++) begin
            step();
            if_req   = 1'($urandom_range(0, 1));
            dm_req   = 1'($urandom_range(0, 1));
            if_addr  = $urandom;
            dm_addr  = $urandom;
            dm_wdata = $urandom;
            dm_be    = BE_W'($urandom);
            dm_we    = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_all_zero($sformatf("rst%0d", i));
        end
        clear_inputs();
        #2 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            chk("idle_no_en", 64'(mem_en), 64'(0));
        end
        step();

        for (int i = 0; i < 6; i++) apply_single(i, vecs[i]);

        // Simultaneous fetch 0x300 and load 0x200: data first, fetch granted in the next IDLE.
        begin
            bit dm_seen, if_seen, dm_done;
            dm_seen = 1'b0;
            if_seen = 1'b0;
            dm_done = 1'b0;
            if_req  = 1'b1;
            if_addr = 32'h0000_0300;
            dm_req  = 1'b1;
            dm_we   = 1'b0;
            dm_be   = 4'hF;
            dm_addr = 32'h0000_0200;
            for (int cyc = 0; cyc < 16 && !if_seen; cyc++) begin
                @(negedge clk);
                chk("sim_ack_onehot", 64'(if_ack && dm_ack), 64'(0));
                chk("sim_stall_if", 64'(stall_if), 64'(cyc != 9));
                if (mem_en && cyc > 1) begin
                    chk("sim_fetch_en_cycle", 64'(cyc), 64'(6));
                    chk("sim_fetch_addr", 64'(mem_addr), 64'(32'h0000_0300));
                end
                if (dm_ack) begin
                    dm_seen = 1'b1;
                    chk("sim_dm_ack_cycle", 64'(cyc), 64'(4));
                    chk("sim_dm_rdata", 64'(dm_rdata), 64'(32'hA5A5_0200));
                end
                if (if_ack) begin
                    if_seen = 1'b1;
                    chk("sim_if_ack_cycle", 64'(cyc), 64'(9));
                    chk("sim_if_rdata", 64'(if_rdata), 64'(32'hA5A5_0300));
                end
                step();
                if (dm_seen && !dm_done) begin
                    dm_req  = 1'b0;
                    dm_done = 1'b1;
                end
                if (if_seen) if_req = 1'b0;
            end
            if (!dm_seen) fail_now("sim_dm_ack_timeout");
            if (!if_seen) fail_now("sim_if_ack_timeout");
            clear_inputs();
        end

        // Four data grants overtake the fetch, the fifth goes to fetch, data resumes.
        run_both(6, 16'h0010, "starve", 1'b0);

        // Build up the grant counter, then reset in WAIT.
        run_both(3, 16'h0000, "pre_rst", 1'b1);
        begin
            bit in_wait;
            in_wait = 1'b0;
            for (int i = 0; i < 8 && !in_wait; i++) begin
                @(negedge clk);
                if (dbg_state == 2'd2) in_wait = 1'b1;
            end
            if (!in_wait) fail_now("rst_reach_wait");
            #2 rst = 1'b0;
            #1;
            check_all_zero("rst_async");
            clear_inputs();
            for (int i = 0; i < 2; i++) begin
                @(negedge clk);
                chk("rst_hold_acks", 64'({if_ack, dm_ack}), 64'(0));
                chk("rst_hold_en", 64'(mem_en), 64'(0));
            end
            #2 rst = 1'b1;
            for (int i = 0; i < 6; i++) begin
                step();
                @(negedge clk);
                chk("post_rst_no_ack", 64'({if_ack, dm_ack}), 64'(0));
                chk("post_rst_no_en", 64'(mem_en), 64'(0));
            end
            step();
        end
        run_both(5, 16'h0010, "post_rst", 1'b0);

        repeat (2) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
